// File: rtl/tlb_mmu.sv
// tlb_mmu: MIPS32 segment decode plus fully-associative joint TLB (4 KB pages).
// Define TLB_MMU_TLB_EN to build the TLB; otherwise mapped segments pass VA through.
module tlb_mmu #(
    parameter int TLB_IDX_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    user_mode,
    input  logic                    kseg0_uncached,
    input  logic                    inst_en,
    input  logic                    data_en,
    input  logic [31:0]             iaddr_i,
    input  logic [31:0]             daddr_i,
    output logic [31:0]             iaddr_o,
    output logic [31:0]             daddr_o,
    output logic                    inst_uncached,
    output logic                    data_uncached,
    output logic                    inst_miss,
    output logic                    data_miss,
    output logic                    inst_invalid,
    output logic                    data_invalid,
    output logic                    data_d,
    output logic                    inst_illegal,
    output logic                    data_illegal,
    input  logic                    tlb_we,
    input  logic [TLB_IDX_BITS-1:0] tlb_index,
    input  logic [31:0]             entryhi_i,
    input  logic [31:0]             entrylo0_i,
    input  logic [31:0]             entrylo1_i,
    input  logic [15:0]             pagemask_i,
    output logic [31:0]             entryhi_o,
    output logic [31:0]             entrylo0_o,
    output logic [31:0]             entrylo1_o,
    output logic [15:0]             pagemask_o,
    output logic [31:0]             probe_o
);
    localparam int N = 1 << TLB_IDX_BITS;

    typedef struct packed {
        logic [31:0] pa;
        logic        unc;
        logic        miss;
        logic        inv;
        logic        d;
        logic        ill;
    } xlat_t;

`ifdef TLB_MMU_TLB_EN
    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
        logic [15:0] mask;
    } tlb_entry_t;

    tlb_entry_t              tlb_q [N];
    tlb_entry_t              entry_d;
    tlb_entry_t              rd_e;
    logic                    probe_hit;
    logic [TLB_IDX_BITS-1:0] probe_idx;

    // Scan downwards so the lowest matching index is the last one kept.
    function automatic logic find(input logic [18:0] vpn2,
                                  input logic [7:0] asid,
                                  output logic [TLB_IDX_BITS-1:0] idx);
        logic hit;
        hit = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (tlb_q[i].vpn2 == vpn2 &&
                (tlb_q[i].g || tlb_q[i].asid == asid)) begin
                hit = 1'b1;
                idx = TLB_IDX_BITS'(i);
            end
        end
        return hit;
    endfunction
`endif

    function automatic xlat_t xlate(input logic [31:0] va, input logic en);
        xlat_t r;
`ifdef TLB_MMU_TLB_EN
        tlb_entry_t              e;
        logic [TLB_IDX_BITS-1:0] idx;
        logic                    hit;
        logic [19:0]             pfn;
        logic [2:0]              c;
        logic                    dd;
        logic                    v;
`endif
        r = '0;
        r.ill = en & user_mode & va[31];
        if (va[31:30] == 2'b10) begin
            // kseg0/kseg1 are unmapped; va[29] distinguishes kseg1
            r.pa  = va & 32'h1FFF_FFFF;
            r.unc = va[29] | kseg0_uncached;
        end else begin
`ifdef TLB_MMU_TLB_EN
            hit = find(va[31:13], entryhi_i[7:0], idx);
            e   = tlb_q[idx];
            pfn = va[12] ? e.pfn1 : e.pfn0;
            c   = va[12] ? e.c1 : e.c0;
            dd  = va[12] ? e.d1 : e.d0;
            v   = va[12] ? e.v1 : e.v0;
            if (hit) begin
                r.pa  = {pfn, va[11:0]};
                r.unc = (c == 3'b010);
                r.d   = dd;
                r.inv = en & ~v;
            end else begin
                r.miss = en;
            end
`else
            r.pa = va;
`endif
        end
        return r;
    endfunction

    xlat_t ix;
    xlat_t dx;

    always_comb begin
        ix = xlate(iaddr_i, inst_en);
        dx = xlate(daddr_i, data_en);
    end

    assign iaddr_o       = ix.pa;
    assign inst_uncached = ix.unc;
    assign inst_miss     = ix.miss;
    assign inst_invalid  = ix.inv;
    assign inst_illegal  = ix.ill;
    assign daddr_o       = dx.pa;
    assign data_uncached = dx.unc;
    assign data_miss     = dx.miss;
    assign data_invalid  = dx.inv;
    assign data_d        = dx.d;
    assign data_illegal  = dx.ill;

    wire unused_id = ix.d;

`ifdef TLB_MMU_TLB_EN
    always_comb begin
        entry_d      = '0;
        entry_d.vpn2 = entryhi_i[31:13];
        entry_d.asid = entryhi_i[7:0];
        entry_d.g    = entrylo0_i[0] & entrylo1_i[0];
        entry_d.pfn0 = entrylo0_i[25:6];
        entry_d.c0   = entrylo0_i[5:3];
        entry_d.d0   = entrylo0_i[2];
        entry_d.v0   = entrylo0_i[1];
        entry_d.pfn1 = entrylo1_i[25:6];
        entry_d.c1   = entrylo1_i[5:3];
        entry_d.d1   = entrylo1_i[2];
        entry_d.v1   = entrylo1_i[1];
        entry_d.mask = pagemask_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) tlb_q[i] <= '0;
        end else if (tlb_we) begin
            tlb_q[tlb_index] <= entry_d;
        end
    end

    always_comb begin
        rd_e      = tlb_q[tlb_index];
        probe_hit = find(entryhi_i[31:13], entryhi_i[7:0], probe_idx);
    end

    assign entryhi_o  = {rd_e.vpn2, 5'b0, rd_e.asid};
    assign entrylo0_o = {6'b0, rd_e.pfn0, rd_e.c0, rd_e.d0, rd_e.v0, rd_e.g};
    assign entrylo1_o = {6'b0, rd_e.pfn1, rd_e.c1, rd_e.d1, rd_e.v1, rd_e.g};
    assign pagemask_o = rd_e.mask;
    assign probe_o    = {~probe_hit, 31'(probe_idx)};

    wire unused_cfg = ^{entryhi_i[12:8], entrylo0_i[31:26], entrylo1_i[31:26]};
`else
    assign entryhi_o  = '0;
    assign entrylo0_o = '0;
    assign entrylo1_o = '0;
    assign pagemask_o = '0;
    assign probe_o    = 32'h8000_0000;

    wire unused_cfg = ^{clk, rst, tlb_we, tlb_index, entryhi_i,
                        entrylo0_i, entrylo1_i, pagemask_i};
`endif

endmodule

// File: tb/tb_tlb_mmu.sv
// tb_tlb_mmu: scoreboard bench for tlb_mmu with an address-map reference model.
// Follows TLB_MMU_TLB_EN in the same way as the design.
module tb_tlb_mmu;
    localparam int IB = 4;
    localparam int N  = 1 << IB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, user_mode, kseg0_uncached, inst_en, data_en;
    logic [31:0]   iaddr_i, daddr_i, iaddr_o, daddr_o;
    logic          inst_uncached, data_uncached, inst_miss, data_miss;
    logic          inst_invalid, data_invalid, data_d;
    logic          inst_illegal, data_illegal, tlb_we;
    logic [IB-1:0] tlb_index;
    logic [31:0]   entryhi_i, entrylo0_i, entrylo1_i;
    logic [15:0]   pagemask_i, pagemask_o;
    logic [31:0]   entryhi_o, entrylo0_o, entrylo1_o, probe_o;

    tlb_mmu #(.TLB_IDX_BITS(IB)) dut (
        .clk(clk), .rst(rst), .user_mode(user_mode),
        .kseg0_uncached(kseg0_uncached),
        .inst_en(inst_en), .data_en(data_en),
        .iaddr_i(iaddr_i), .daddr_i(daddr_i),
        .iaddr_o(iaddr_o), .daddr_o(daddr_o),
        .inst_uncached(inst_uncached), .data_uncached(data_uncached),
        .inst_miss(inst_miss), .data_miss(data_miss),
        .inst_invalid(inst_invalid), .data_invalid(data_invalid),
        .data_d(data_d),
        .inst_illegal(inst_illegal), .data_illegal(data_illegal),
        .tlb_we(tlb_we), .tlb_index(tlb_index),
        .entryhi_i(entryhi_i), .entrylo0_i(entrylo0_i),
        .entrylo1_i(entrylo1_i), .pagemask_i(pagemask_i),
        .entryhi_o(entryhi_o), .entrylo0_o(entrylo0_o),
        .entrylo1_o(entrylo1_o), .pagemask_o(pagemask_o),
        .probe_o(probe_o)
    );

    typedef struct packed {
        logic [31:0] ipa;
        logic [31:0] dpa;
        logic [3:0]  ifl;
        logic [4:0]  dfl;
        logic [31:0] hi;
        logic [31:0] lo0;
        logic [31:0] lo1;
        logic [15:0] pm;
        logic [31:0] pr;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    // Model TLB: raw register words with the unstored bits masked off.
    logic [31:0] m_hi [N];
    logic [31:0] m_lo0[N];
    logic [31:0] m_lo1[N];
    logic        m_g  [N];
    logic [15:0] m_pm [N];

    task automatic m_clear();
        for (int i = 0; i < N; i++) begin
            m_hi[i] = 0; m_lo0[i] = 0; m_lo1[i] = 0; m_g[i] = 0; m_pm[i] = 0;
        end
    endtask

    function automatic logic lookup(input logic [18:0] vpn,
                                    input logic [7:0] asid,
                                    output int idx);
        idx = 0;
        for (int i = 0; i < N; i++) begin
            if (m_hi[i][31:13] == vpn && (m_g[i] || m_hi[i][7:0] == asid)) begin
                idx = i;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic void xl(input logic [31:0] va, input logic en,
                               output logic [31:0] pa, output logic u,
                               output logic m, output logic iv,
                               output logic d, output logic il);
        int          idx;
        logic [31:0] lo;
        pa = 0; u = 0; m = 0; iv = 0; d = 0;
        il = en && user_mode && va >= 32'h8000_0000;
        if (va >= 32'h8000_0000 && va < 32'hA000_0000) begin
            pa = va - 32'h8000_0000;
            u  = kseg0_uncached;
        end else if (va >= 32'hA000_0000 && va < 32'hC000_0000) begin
            pa = va - 32'hA000_0000;
            u  = 1'b1;
        end else begin
`ifdef TLB_MMU_TLB_EN
            if (!lookup(va[31:13], entryhi_i[7:0], idx)) begin
                m = en;
            end else begin
                lo = va[12] ? m_lo1[idx] : m_lo0[idx];
                pa = {lo[25:6], va[11:0]};
                u  = lo[5:3] == 3'd2;
                d  = lo[2];
                iv = en && !lo[1];
            end
`else
            pa = va;
`endif
        end
    endfunction

    function automatic exp_t predict();
        exp_t        x;
        logic [31:0] pa;
        logic        u, m, iv, d, il;
        int          idx;
        x = '0;
        xl(iaddr_i, inst_en, pa, u, m, iv, d, il);
        x.ipa = pa;
        x.ifl = {u, m, iv, il};
        xl(daddr_i, data_en, pa, u, m, iv, d, il);
        x.dpa = pa;
        x.dfl = {u, m, iv, d, il};
`ifdef TLB_MMU_TLB_EN
        x.hi  = m_hi[tlb_index];
        x.lo0 = m_lo0[tlb_index] | {31'b0, m_g[tlb_index]};
        x.lo1 = m_lo1[tlb_index] | {31'b0, m_g[tlb_index]};
        x.pm  = m_pm[tlb_index];
        if (lookup(entryhi_i[31:13], entryhi_i[7:0], idx)) x.pr = idx;
        else x.pr = 32'h8000_0000;
`else
        x.pr = 32'h8000_0000;
`endif
        return x;
    endfunction

    // One cycle: queue the expectation, then let the edge commit writes/reset.
    task automatic issue();
        q.push_back(predict());
        @(posedge clk);
        #1;
        if (rst) begin
            m_clear();
        end else if (tlb_we) begin
            m_hi[tlb_index]  = entryhi_i & 32'hFFFF_E0FF;
            m_lo0[tlb_index] = entrylo0_i & 32'h03FF_FFFE;
            m_lo1[tlb_index] = entrylo1_i & 32'h03FF_FFFE;
            m_g[tlb_index]   = entrylo0_i[0] & entrylo1_i[0];
            m_pm[tlb_index]  = pagemask_i;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, a, e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("iaddr_o", iaddr_o, e.ipa);
                chk("daddr_o", daddr_o, e.dpa);
                chk("inst_flags",
                    {28'b0, inst_uncached, inst_miss, inst_invalid, inst_illegal},
                    {28'b0, e.ifl});
                chk("data_flags",
                    {27'b0, data_uncached, data_miss, data_invalid, data_d, data_illegal},
                    {27'b0, e.dfl});
                chk("entryhi_o", entryhi_o, e.hi);
                chk("entrylo0_o", entrylo0_o, e.lo0);
                chk("entrylo1_o", entrylo1_o, e.lo1);
                chk("pagemask_o", {16'b0, pagemask_o}, {16'b0, e.pm});
                chk("probe_o", probe_o, e.pr);
            end
        end
    end

    function automatic logic [18:0] rand_vpn();
        logic [18:0] k;
        k = 19'($urandom_range(0, 5));
        return $urandom_range(0, 1) ? 19'h60000 + k : k;
    endfunction

    function automatic logic [31:0] rand_va();
        case ($urandom_range(0, 3))
            0, 1:    return {rand_vpn(), 13'($urandom)};
            2:       return {3'b100, 29'($urandom)};
            default: return {3'b101, 29'($urandom)};
        endcase
    endfunction

    initial begin
        rst = 1; user_mode = 0; kseg0_uncached = 0;
        inst_en = 0; data_en = 0; iaddr_i = 0; daddr_i = 0;
        tlb_we = 0; tlb_index = 0; entryhi_i = 0;
        entrylo0_i = 0; entrylo1_i = 0; pagemask_i = 0;
        m_clear();
        repeat (3) @(posedge clk);
        #1;
        rst = 0;

        inst_en = 1; data_en = 1; iaddr_i = 32'h0000_0004; daddr_i = 0;
        issue();
        daddr_i = 32'h8000_1234; kseg0_uncached = 1;
        issue();
        kseg0_uncached = 0;
        issue();
        iaddr_i = 32'hBFC0_0000;
        issue();

        tlb_index  = 3;
        entryhi_i  = 32'h0080_0005;
        entrylo0_i = 32'h048D_141E;
        entrylo1_i = 32'h0000_0000;
        pagemask_i = 16'h1FFF;
        daddr_i    = 32'h0080_0ABC;
        tlb_we     = 1;
        issue();
        tlb_we = 0;
        issue();
        daddr_i = 32'h0080_1000;
        issue();
        entryhi_i = 32'h0080_0006; daddr_i = 32'h0080_0ABC;
        issue();
        entryhi_i = 32'h0090_0005;
        issue();

        user_mode = 1; daddr_i = 32'hC000_0000;
        issue();
        data_en = 0;
        issue();

        for (int k = 0; k < 1500; k++) begin
            user_mode      = $urandom_range(0, 3) == 0;
            kseg0_uncached = 1'($urandom);
            inst_en        = $urandom_range(0, 7) != 0;
            data_en        = $urandom_range(0, 7) != 0;
            iaddr_i        = rand_va();
            daddr_i        = rand_va();
            tlb_we         = $urandom_range(0, 3) == 0;
            tlb_index      = IB'($urandom);
            entryhi_i      = {rand_vpn(), 5'($urandom), 8'($urandom_range(0, 3))};
            entrylo0_i     = $urandom;
            entrylo1_i     = $urandom;
            pagemask_i     = 16'($urandom);
            rst            = $urandom_range(0, 99) == 0;
            issue();
        end
        rst = 0; tlb_we = 0;

        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d pending, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
